// File: rtl/imager_mem_fsm_pkg.sv
// Shared constants for the coded-exposure mask memory sequencer:
// MCB instruction codes, frame/burst geometry defaults and FSM state encodings.
package imager_mem_fsm_pkg;

  localparam int FRAME_WORDS_DEF = 1440;
  localparam int BURST_DEF       = 32;

  localparam logic [2:0] MCB_WR = 3'b000;
  localparam logic [2:0] MCB_RD = 3'b001;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_WAIT_CAL = 3'd1;
  localparam state_t ST_LD_FILL  = 3'd2;
  localparam state_t ST_LD_CMD   = 3'd3;
  localparam state_t ST_PB_CMD   = 3'd4;
  localparam state_t ST_PB_DATA  = 3'd5;
  localparam state_t ST_HS_REQ   = 3'd6;
  localparam state_t ST_HS_ACK   = 3'd7;

  localparam logic [1:0] HS_ST_IDLE = 2'd0;
  localparam logic [1:0] HS_ST_REQ  = 2'd1;
  localparam logic [1:0] HS_ST_ACK  = 2'd2;

endpackage

// File: rtl/imager_fsmind_hs.sv
// Per-frame sensor handshake: raise fsmind1 on start, wait for ack plus fsmind0, then hold fsmind0ack.
// Each step registers one cycle after its input is sampled; an early fsmind0 is held off until the ack.
module imager_fsmind_hs
  import imager_mem_fsm_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic fsmind1ack,
  input  logic fsmind0,
  output logic fsmind1,
  output logic fsmind0ack,
  output logic hs_done
);

  logic [1:0] hs_state;
  logic       ack_seen;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hs_state <= HS_ST_IDLE;
      ack_seen <= 1'b0;
    end else begin
      case (hs_state)
        HS_ST_IDLE: begin
          if (start) begin
            hs_state <= HS_ST_REQ;
            ack_seen <= 1'b0;
          end
        end
        HS_ST_REQ: begin
          if (fsmind1ack) ack_seen <= 1'b1;
          // Only an ack already latched lets fsmind0 through.
          if (fsmind0 && ack_seen) hs_state <= HS_ST_ACK;
        end
        HS_ST_ACK: begin
          if (!fsmind0) hs_state <= HS_ST_IDLE;
        end
        default: hs_state <= HS_ST_IDLE;
      endcase
    end
  end

  assign fsmind1    = (hs_state == HS_ST_REQ);
  assign fsmind0ack = (hs_state == HS_ST_ACK);
  assign hs_done    = (hs_state == HS_ST_ACK) && !fsmind0;

endmodule

// File: rtl/imager_mem_fsm.sv
// Loads mask frames from the pipe-in FIFO into DDR2 in bursts, then replays them into the mask FIFO with a sensor handshake per frame.
// One word per cycle when the source is non-empty and the sink not full; commands wait for cmd_full to clear.
module imager_mem_fsm
  import imager_mem_fsm_pkg::*;
#(
  parameter int FRAME_WORDS = FRAME_WORDS_DEF,
  parameter int BURST       = BURST_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        calib_done,
  input  logic [15:0] num_pat,
  input  logic [15:0] exp_cnt,
  input  logic        trig_load,
  input  logic [31:0] pi_data,
  input  logic        pi_empty,
  output logic        pi_rd_en,
  output logic        cmd_en,
  output logic [2:0]  cmd_instr,
  output logic [5:0]  cmd_bl,
  output logic [29:0] cmd_byte_addr,
  input  logic        cmd_full,
  output logic        wr_en,
  output logic [31:0] wr_data,
  output logic [3:0]  wr_mask,
  input  logic        wr_full,
  output logic        rd_en,
  input  logic [31:0] rd_data,
  input  logic        rd_empty,
  output logic        mask_wr_en,
  output logic [31:0] mask_data,
  input  logic        mask_full,
  output logic        FSMIND1,
  input  logic        FSMIND1ACK,
  input  logic        FSMIND0,
  output logic        FSMIND0ACK,
  output logic        busy,
  output logic        done,
  output logic [15:0] frame_idx
);

  localparam int BURSTS = FRAME_WORDS / BURST;
  localparam int WCW    = $clog2(BURST) + 1;

  state_t         state;
  logic [15:0]    frame;
  logic [15:0]    pass;
  logic [15:0]    burst;
  logic [WCW-1:0] wcnt;

  logic ld_move, pb_move, wcnt_last, burst_last, frame_last, pass_last;
  logic hs_start, hs_done, hs_fin;
  logic [29:0] frame_base, burst_off;

  assign ld_move    = (state == ST_LD_FILL) && !pi_empty && !wr_full;
  assign pb_move    = (state == ST_PB_DATA) && !rd_empty && !mask_full;
  assign wcnt_last  = (wcnt == WCW'(BURST - 1));
  assign burst_last = (burst == 16'(BURSTS - 1));
  assign frame_last = (frame == (num_pat - 16'd1));
  assign pass_last  = ((pass + 16'd1) == exp_cnt);
  assign hs_start   = pb_move && wcnt_last && burst_last;
  assign hs_fin     = ((state == ST_HS_REQ) || (state == ST_HS_ACK)) && hs_done;

  // Address arithmetic is deliberately 30-bit and wraps silently.
  assign frame_base    = 30'(frame) * 30'(FRAME_WORDS * 4);
  assign burst_off     = 30'(burst) * 30'(BURST * 4);
  assign cmd_byte_addr = frame_base + burst_off;

  assign pi_rd_en   = ld_move;
  assign wr_en      = ld_move;
  assign wr_data    = ld_move ? pi_data : 32'd0;
  assign wr_mask    = 4'd0;
  assign rd_en      = pb_move;
  assign mask_wr_en = pb_move;
  assign mask_data  = pb_move ? rd_data : 32'd0;
  assign cmd_en     = ((state == ST_LD_CMD) || (state == ST_PB_CMD)) && !cmd_full;
  assign cmd_instr  = (state == ST_PB_CMD) ? MCB_RD : MCB_WR;
  assign busy       = (state != ST_IDLE);
  assign cmd_bl     = busy ? 6'(BURST - 1) : 6'd0;
  assign frame_idx  = frame;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      frame <= '0;
      pass  <= '0;
      burst <= '0;
      wcnt  <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (trig_load) begin
            state <= ST_WAIT_CAL;
            frame <= '0;
            pass  <= '0;
            burst <= '0;
            wcnt  <= '0;
          end
        end
        ST_WAIT_CAL: begin
          if (calib_done) begin
            if (num_pat == 16'd0) begin
              done  <= 1'b1;
              state <= ST_IDLE;
            end else begin
              state <= ST_LD_FILL;
            end
          end
        end
        ST_LD_FILL: begin
          if (ld_move) begin
            if (wcnt_last) begin
              wcnt  <= '0;
              state <= ST_LD_CMD;
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end
        end
        ST_LD_CMD: begin
          if (!cmd_full) begin
            if (!burst_last) begin
              burst <= burst + 16'd1;
              state <= ST_LD_FILL;
            end else if (!frame_last) begin
              burst <= '0;
              frame <= frame + 16'd1;
              state <= ST_LD_FILL;
            end else begin
              burst <= '0;
              frame <= '0;
              pass  <= '0;
              if (exp_cnt == 16'd0) begin
                done  <= 1'b1;
                state <= ST_IDLE;
              end else begin
                state <= ST_PB_CMD;
              end
            end
          end
        end
        ST_PB_CMD: begin
          if (!cmd_full) state <= ST_PB_DATA;
        end
        ST_PB_DATA: begin
          if (pb_move) begin
            if (wcnt_last) begin
              wcnt <= '0;
              if (burst_last) begin
                burst <= '0;
                state <= ST_HS_REQ;
              end else begin
                burst <= burst + 16'd1;
                state <= ST_PB_CMD;
              end
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end
        end
        ST_HS_REQ, ST_HS_ACK: begin
          // The sensor may drop FSMIND0 before HS_ACK is reached, so both states watch for completion.
          if (hs_fin) begin
            if (!frame_last) begin
              frame <= frame + 16'd1;
              state <= ST_PB_CMD;
            end else begin
              frame <= '0;
              if (pass_last) begin
                done  <= 1'b1;
                state <= ST_IDLE;
              end else begin
                pass  <= pass + 16'd1;
                state <= ST_PB_CMD;
              end
            end
          end else if (FSMIND0ACK) begin
            state <= ST_HS_ACK;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  imager_fsmind_hs u_hs (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (hs_start),
    .fsmind1ack (FSMIND1ACK),
    .fsmind0    (FSMIND0),
    .fsmind1    (FSMIND1),
    .fsmind0ack (FSMIND0ACK),
    .hs_done    (hs_done)
  );

endmodule

// File: tb/tb_imager_mem_fsm.sv
// Directed bench for imager_mem_fsm with FWFT FIFO, MCB memory and sensor handshake models.
`timescale 1ns/1ps
module tb_imager_mem_fsm;
  localparam int FW = 1440, BL = 32, BPF = 45;

  logic clk;
  logic rst_n, calib_done, trig_load;
  logic [15:0] num_pat, exp_cnt;
  logic [31:0] pi_data;  logic pi_empty, pi_rd_en;
  logic cmd_en; logic [2:0] cmd_instr; logic [5:0] cmd_bl; logic [29:0] cmd_byte_addr; logic cmd_full;
  logic wr_en; logic [31:0] wr_data; logic [3:0] wr_mask; logic wr_full;
  logic rd_en; logic [31:0] rd_data; logic rd_empty;
  logic mask_wr_en; logic [31:0] mask_data; logic mask_full;
  logic FSMIND1, FSMIND1ACK, FSMIND0, FSMIND0ACK, busy, done;
  logic [15:0] frame_idx;

  imager_mem_fsm dut (
    .clk(clk), .rst_n(rst_n), .calib_done(calib_done), .num_pat(num_pat), .exp_cnt(exp_cnt),
    .trig_load(trig_load), .pi_data(pi_data), .pi_empty(pi_empty), .pi_rd_en(pi_rd_en),
    .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl), .cmd_byte_addr(cmd_byte_addr),
    .cmd_full(cmd_full), .wr_en(wr_en), .wr_data(wr_data), .wr_mask(wr_mask), .wr_full(wr_full),
    .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty), .mask_wr_en(mask_wr_en),
    .mask_data(mask_data), .mask_full(mask_full), .FSMIND1(FSMIND1), .FSMIND1ACK(FSMIND1ACK),
    .FSMIND0(FSMIND0), .FSMIND0ACK(FSMIND0ACK), .busy(busy), .done(done), .frame_idx(frame_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  int cyc = 0;
  bit pend_rst, pend_trig, stall_en;
  logic [31:0] pi_q[$], wq[$], rd_q[$], mask_log[$];
  logic [29:0] wr_addr_log[$], rd_addr_log[$];
  logic [15:0] frame_log[$];
  logic [31:0] mem [0:8191];
  int viol, hs_viol, done_cnt, hs_cnt;
  int ack_dly = 2, f0_dly = 4;
  bit sens_active, saw_ack0;
  int sens_cnt;
  int trig_cyc, first_pird_cyc, last_mask_cyc;
  int f1_rise_cyc, f1_fall_cyc, f0_rise_cyc, f0ack_rise_cyc, ack1_rise_cyc;
  bit prev_f1, prev_f0ack, prev_ack1, prev_f0;

  // One clock of the environment: drive at negedge, observe 1ns later, update models.
  task automatic step();
    @(negedge clk);
    rst_n = !pend_rst;
    pend_rst = 1'b0;
    trig_load = pend_trig;
    if (pend_trig) trig_cyc = cyc;
    pend_trig = 1'b0;
    cmd_full  = stall_en && ($urandom_range(0, 3) == 0);
    wr_full   = stall_en && ($urandom_range(0, 3) == 0);
    mask_full = stall_en && ($urandom_range(0, 3) == 0);
    pi_empty  = (pi_q.size() == 0) || (stall_en && ($urandom_range(0, 3) == 0));
    pi_data   = (pi_q.size() != 0) ? pi_q[0] : 32'hdead_beef;
    rd_empty  = (rd_q.size() == 0) || (stall_en && ($urandom_range(0, 3) == 0));
    rd_data   = (rd_q.size() != 0) ? rd_q[0] : 32'hbad0_bad0;
    FSMIND1ACK = sens_active && !saw_ack0 && (sens_cnt >= ack_dly);
    FSMIND0    = sens_active && !saw_ack0 && (sens_cnt >= f0_dly);
    #1;
    if (FSMIND1ACK && !prev_ack1) ack1_rise_cyc = cyc;
    if (FSMIND0 && !prev_f0) f0_rise_cyc = cyc;
    if (FSMIND1 && !prev_f1) begin f1_rise_cyc = cyc; frame_log.push_back(frame_idx); end
    if (!FSMIND1 && prev_f1) f1_fall_cyc = cyc;
    if (FSMIND0ACK && !prev_f0ack) f0ack_rise_cyc = cyc;
    prev_ack1 = FSMIND1ACK; prev_f0 = FSMIND0; prev_f1 = FSMIND1; prev_f0ack = FSMIND0ACK;
    if ((cmd_en && cmd_full) || (pi_rd_en && pi_empty) || (wr_en && wr_full) ||
        (rd_en && rd_empty) || (mask_wr_en && mask_full) || (pi_rd_en !== wr_en) ||
        (rd_en !== mask_wr_en) || (wr_mask !== 4'd0)) viol++;
    if (pi_rd_en) begin
      if (first_pird_cyc < 0) first_pird_cyc = cyc;
      if (pi_q.size() != 0) void'(pi_q.pop_front());
    end
    if (wr_en) wq.push_back(wr_data);
    if (cmd_en) begin
      if (cmd_bl !== 6'd31) viol++;
      if (cmd_instr === 3'b000) begin
        wr_addr_log.push_back(cmd_byte_addr);
        if (wq.size() != BL) viol++;
        for (int i = 0; i < BL; i++)
          if (wq.size() != 0) mem[(int'(cmd_byte_addr >> 2) + i) % 8192] = wq.pop_front();
      end else if (cmd_instr === 3'b001) begin
        rd_addr_log.push_back(cmd_byte_addr);
        for (int i = 0; i < BL; i++) rd_q.push_back(mem[(int'(cmd_byte_addr >> 2) + i) % 8192]);
      end else begin
        viol++;
      end
    end
    if (rd_en && rd_q.size() != 0) void'(rd_q.pop_front());
    if (mask_wr_en) begin
      mask_log.push_back(mask_data);
      if (mask_log.size() % FW == 0) last_mask_cyc = cyc;
    end
    if (done) done_cnt++;
    if (sens_active) begin
      sens_cnt++;
      if (FSMIND0ACK) saw_ack0 = 1'b1;
      else if (saw_ack0) sens_active = 1'b0;
    end
    if (sens_active && cmd_en) hs_viol++;
    if (FSMIND1 && !sens_active) begin
      sens_active = 1'b1; sens_cnt = 0; saw_ack0 = 1'b0; hs_cnt++;
    end
    cyc++;
  endtask

  task automatic clear_model();
    pi_q.delete(); wq.delete(); rd_q.delete(); mask_log.delete();
    wr_addr_log.delete(); rd_addr_log.delete(); frame_log.delete();
    viol = 0; hs_viol = 0; done_cnt = 0; hs_cnt = 0;
    sens_active = 1'b0; saw_ack0 = 1'b0; sens_cnt = 0;
    first_pird_cyc = -1; last_mask_cyc = -1; trig_cyc = -1;
    f1_rise_cyc = -1; f1_fall_cyc = -1; f0_rise_cyc = -1; f0ack_rise_cyc = -1; ack1_rise_cyc = -1;
  endtask

  task automatic start_load(input int np, input int ec, input logic [31:0] base);
    num_pat = 16'(np);
    exp_cnt = 16'(ec);
    for (int k = 0; k < np * FW; k++) pi_q.push_back(base + 32'(k));
    pend_trig = 1'b1;
  endtask

  task automatic run_done(input int budget, output bit timed_out);
    int start_cnt;
    start_cnt = done_cnt;
    for (int i = 0; i < budget; i++) begin
      step();
      if (done_cnt != start_cnt) break;
    end
    timed_out = (done_cnt == start_cnt);
    repeat (5) step();
  endtask

  task automatic test_reset();
    pend_rst = 1'b1; step();
    pend_rst = 1'b1; step();
    step();
    n_checks++;
    if ({pi_rd_en, cmd_en, cmd_instr, cmd_bl, cmd_byte_addr, wr_en, wr_data, wr_mask, rd_en,
         mask_wr_en, mask_data, FSMIND1, FSMIND0ACK, done} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: outputs not all zero, cmd_en=%b addr=%h", cmd_en, cmd_byte_addr);
    end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++;
    if (frame_idx !== 16'd0) begin n_fail++; $display("FAIL reset_frame_idx: got %0d want 0", frame_idx); end
  endtask

  task automatic test_reset_mid();
    clear_model();
    start_load(1, 1, 32'd0);
    repeat (12) step();
    n_checks++;
    if (!(busy === 1'b1 && wr_en === 1'b1)) begin
      n_fail++; $display("FAIL mid_fill_active: busy=%b wr_en=%b want 1/1", busy, wr_en);
    end
    pend_rst = 1'b1; step();
    step();
    n_checks++;
    if ({pi_rd_en, cmd_en, cmd_instr, cmd_bl, cmd_byte_addr, wr_en, wr_data, wr_mask, rd_en,
         mask_wr_en, mask_data, FSMIND1, FSMIND0ACK, done, frame_idx} !== '0) begin
      n_fail++; $display("FAIL mid_reset_outputs: outputs not all zero, wr_en=%b pi_rd_en=%b", wr_en, pi_rd_en);
    end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_single();
    bit to; int bad;
    clear_model();
    start_load(1, 1, 32'd0);
    run_done(20000, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL single_timeout: no done within budget"); end
    n_checks++;
    if (first_pird_cyc - trig_cyc !== 2) begin
      n_fail++; $display("FAIL trig_latency: got %0d want 2", first_pird_cyc - trig_cyc);
    end
    n_checks++;
    if (wr_addr_log.size() !== BPF) begin n_fail++; $display("FAIL single_wr_count: got %0d want %0d", wr_addr_log.size(), BPF); end
    bad = 0;
    foreach (wr_addr_log[j]) if (wr_addr_log[j] !== 30'(j * 128)) bad++;
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL single_wr_addr: %0d wrong addresses, want 0", bad); end
    n_checks++;
    if (rd_addr_log.size() !== BPF) begin n_fail++; $display("FAIL single_rd_count: got %0d want %0d", rd_addr_log.size(), BPF); end
    bad = 0;
    foreach (rd_addr_log[j]) if (rd_addr_log[j] !== 30'(j * 128)) bad++;
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL single_rd_addr: %0d wrong addresses, want 0", bad); end
    bad = 0;
    foreach (mask_log[m]) if (mask_log[m] !== 32'(m)) bad++;
    n_checks++;
    if (mask_log.size() !== FW || bad !== 0) begin
      n_fail++; $display("FAIL single_mask_data: size %0d bad %0d, want %0d/0", mask_log.size(), bad, FW);
    end
    n_checks++;
    if (f1_rise_cyc !== last_mask_cyc + 1) begin
      n_fail++; $display("FAIL fsmind1_rise: at %0d want %0d", f1_rise_cyc, last_mask_cyc + 1);
    end
    n_checks++;
    if (done_cnt !== 1 || hs_cnt !== 1) begin
      n_fail++; $display("FAIL single_done_hs: done=%0d hs=%0d want 1/1", done_cnt, hs_cnt);
    end
    n_checks++;
    if (viol !== 0 || hs_viol !== 0) begin
      n_fail++; $display("FAIL single_protocol: viol=%0d hs_viol=%0d want 0/0", viol, hs_viol);
    end
  endtask

  task automatic test_multi();
    bit to; int bad;
    clear_model();
    start_load(3, 2, 32'h1000_0000);
    run_done(40000, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL multi_timeout: no done within budget"); end
    bad = 0;
    foreach (wr_addr_log[j]) if (wr_addr_log[j] !== 30'((j / BPF) * 5760 + (j % BPF) * 128)) bad++;
    n_checks++;
    if (wr_addr_log.size() !== 3 * BPF || bad !== 0) begin
      n_fail++; $display("FAIL multi_wr_addr: count %0d bad %0d, want %0d/0", wr_addr_log.size(), bad, 3 * BPF);
    end
    bad = 0;
    foreach (rd_addr_log[j]) if (rd_addr_log[j] !== 30'(((j / BPF) % 3) * 5760 + (j % BPF) * 128)) bad++;
    n_checks++;
    if (rd_addr_log.size() !== 6 * BPF || bad !== 0) begin
      n_fail++; $display("FAIL multi_rd_addr: count %0d bad %0d, want %0d/0", rd_addr_log.size(), bad, 6 * BPF);
    end
    bad = 0;
    foreach (mask_log[m]) if (mask_log[m] !== 32'h1000_0000 + 32'(m % (3 * FW))) bad++;
    n_checks++;
    if (mask_log.size() !== 6 * FW || bad !== 0) begin
      n_fail++; $display("FAIL multi_mask_data: size %0d bad %0d, want %0d/0", mask_log.size(), bad, 6 * FW);
    end
    bad = 0;
    foreach (frame_log[f]) if (frame_log[f] !== 16'(f % 3)) bad++;
    n_checks++;
    if (frame_log.size() !== 6 || bad !== 0 || hs_cnt !== 6) begin
      n_fail++; $display("FAIL multi_frame_order: frames %0d bad %0d hs %0d, want 6/0/6", frame_log.size(), bad, hs_cnt);
    end
    n_checks++;
    if (done_cnt !== 1 || viol !== 0) begin
      n_fail++; $display("FAIL multi_done: done=%0d viol=%0d want 1/0", done_cnt, viol);
    end
  endtask

  task automatic test_sensor();
    bit to;
    clear_model();
    ack_dly = 1000; f0_dly = 2000;
    start_load(1, 1, 32'h2000_0000);
    run_done(20000, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL sensor_timeout: no done within budget"); end
    n_checks++;
    if (f1_fall_cyc !== f0_rise_cyc + 1) begin
      n_fail++; $display("FAIL fsmind1_fall: at %0d want %0d", f1_fall_cyc, f0_rise_cyc + 1);
    end
    n_checks++;
    if (f0ack_rise_cyc !== f0_rise_cyc + 1) begin
      n_fail++; $display("FAIL fsmind0ack_rise: at %0d want %0d", f0ack_rise_cyc, f0_rise_cyc + 1);
    end
    n_checks++;
    if (hs_viol !== 0 || hs_cnt !== 1) begin
      n_fail++; $display("FAIL sensor_read_hold: hs_viol=%0d hs=%0d want 0/1", hs_viol, hs_cnt);
    end
    clear_model();
    ack_dly = 20; f0_dly = 5;
    start_load(1, 1, 32'h3000_0000);
    run_done(20000, to);
    n_checks++;
    if (to || f0ack_rise_cyc !== ack1_rise_cyc + 2 || f1_fall_cyc !== ack1_rise_cyc + 2) begin
      n_fail++; $display("FAIL early_fsmind0_holdoff: f0ack %0d f1fall %0d want %0d", f0ack_rise_cyc, f1_fall_cyc, ack1_rise_cyc + 2);
    end
    ack_dly = 2; f0_dly = 4;
  endtask

  task automatic test_stall();
    bit to; int bad;
    clear_model();
    stall_en = 1'b1;
    start_load(2, 1, 32'ha500_0000);
    run_done(40000, to);
    stall_en = 1'b0;
    n_checks++;
    if (to) begin n_fail++; $display("FAIL stall_timeout: no done within budget"); end
    bad = 0;
    foreach (mask_log[m]) if (mask_log[m] !== 32'ha500_0000 + 32'(m)) bad++;
    n_checks++;
    if (mask_log.size() !== 2 * FW || bad !== 0) begin
      n_fail++; $display("FAIL stall_data: size %0d bad %0d, want %0d/0", mask_log.size(), bad, 2 * FW);
    end
    n_checks++;
    if (wr_addr_log.size() !== 2 * BPF || rd_addr_log.size() !== 2 * BPF) begin
      n_fail++; $display("FAIL stall_cmd_count: wr %0d rd %0d want %0d", wr_addr_log.size(), rd_addr_log.size(), 2 * BPF);
    end
    n_checks++;
    if (viol !== 0) begin n_fail++; $display("FAIL stall_protocol: %0d violations want 0", viol); end
  endtask

  task automatic test_zero();
    bit to;
    clear_model();
    start_load(0, 1, 32'd0);
    run_done(50, to);
    n_checks++;
    if (to || done_cnt !== 1 || wr_addr_log.size() !== 0 || rd_addr_log.size() !== 0) begin
      n_fail++; $display("FAIL num_pat_zero: done %0d wr %0d rd %0d want 1/0/0", done_cnt, wr_addr_log.size(), rd_addr_log.size());
    end
    clear_model();
    start_load(1, 0, 32'd0);
    run_done(5000, to);
    n_checks++;
    if (to || done_cnt !== 1 || wr_addr_log.size() !== BPF || rd_addr_log.size() !== 0 || hs_cnt !== 0) begin
      n_fail++; $display("FAIL exp_cnt_zero: done %0d wr %0d rd %0d hs %0d want 1/%0d/0/0", done_cnt, wr_addr_log.size(), rd_addr_log.size(), hs_cnt, BPF);
    end
    clear_model();
    calib_done = 1'b0;
    start_load(1, 1, 32'd0);
    repeat (100) step();
    n_checks++;
    if (busy !== 1'b1 || first_pird_cyc !== -1 || wr_addr_log.size() !== 0 || rd_addr_log.size() !== 0) begin
      n_fail++; $display("FAIL calib_hold: busy %b pird %0d cmds %0d want 1/-1/0", busy, first_pird_cyc, wr_addr_log.size() + rd_addr_log.size());
    end
    calib_done = 1'b1;
    run_done(20000, to);
    n_checks++;
    if (to || done_cnt !== 1) begin n_fail++; $display("FAIL calib_release: done %0d want 1", done_cnt); end
  endtask

  initial begin
    rst_n = 1'b0; calib_done = 1'b1; trig_load = 1'b0; num_pat = '0; exp_cnt = '0;
    pi_data = '0; pi_empty = 1'b1; cmd_full = 1'b0; wr_full = 1'b0; rd_data = '0;
    rd_empty = 1'b1; mask_full = 1'b0; FSMIND1ACK = 1'b0; FSMIND0 = 1'b0;
    pend_rst = 1'b0; pend_trig = 1'b0; stall_en = 1'b0;
    for (int i = 0; i < 8192; i++) mem[i] = 32'h0;
    clear_model();
    test_reset();
    test_reset_mid();
    test_single();
    test_multi();
    test_sensor();
    test_stall();
    test_zero();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imager_mem_fsm.md
# imager_mem_fsm

Memory-sequencing controller for the coded-exposure imager FPGA. On a load trigger it streams mask patterns from the host pipe-in FIFO into DDR2 through one MCB user port, in 32-word bursts. It then plays the patterns back frame by frame into the mask-stream FIFO, and handshakes each frame with the sensor over FSMIND1/FSMIND0.

## Interface
- FRAME_WORDS, 1440: 32-bit words per pattern frame (160×18×2 bytes).
- BURST, 32: words per MCB command; FRAME_WORDS must be a multiple of it.
- clk in 1: sole clock (MCB user-port clock).
- rst_n in 1: reset; synchronous, active-low.
- calib_done in 1: MCB calibration complete.
- num_pat in 16: frames to load and play.
- exp_cnt in 16: playback passes over all frames.
- trig_load in 1: one-cycle load-start pulse.
- pi_data in 32, pi_empty in 1, pi_rd_en out 1: pipe-in FIFO, first-word-fall-through.
- cmd_en out 1, cmd_instr out 3 (000 write, 001 read), cmd_bl out 6 (=BURST-1), cmd_byte_addr out 30, cmd_full in 1: MCB command port.
- wr_en out 1, wr_data out 32, wr_mask out 4 (always 0), wr_full in 1: MCB write port.
- rd_en out 1, rd_data in 32, rd_empty in 1: MCB read port, FWFT.
- mask_wr_en out 1, mask_data out 32, mask_full in 1: mask-stream FIFO.
- FSMIND1 out 1, FSMIND1ACK in 1, FSMIND0 in 1, FSMIND0ACK out 1: sensor frame handshake.
- busy out 1, done out 1 (one-cycle pulse), frame_idx out 16.

## Operation
- States: IDLE, WAIT_CAL, LD_FILL, LD_CMD, PB_CMD, PB_DATA, HS_REQ, HS_ACK.
- IDLE: trig_load → WAIT_CAL. trig_load in any other state is ignored.
- WAIT_CAL: stay until calib_done=1. If num_pat=0, pulse done and go to IDLE. Otherwise → LD_FILL.
- LD_FILL: move one word per cycle while !pi_empty && !wr_full (pi_rd_en=wr_en, wr_data=pi_data). After BURST words → LD_CMD.
- LD_CMD: when !cmd_full, pulse cmd_en with instr 000 and addr = frame·FRAME_WORDS·4 + burst·BURST·4.
  - If more bursts remain → LD_FILL.
  - After the final burst of frame num_pat-1 → PB_CMD with frame=0, pass=0.
  - If exp_cnt=0, pulse done and go to IDLE instead.
- PB_CMD: when !cmd_full, pulse a read command (same address formula) → PB_DATA.
- PB_DATA: move one word per cycle while !rd_empty && !mask_full (rd_en=mask_wr_en, mask_data=rd_data). After BURST words:
  - next burst → PB_CMD;
  - frame complete → HS_REQ.
- HS_REQ: FSMIND1=1. Latch FSMIND1ACK when seen high. When FSMIND0=1 and the ack is latched: FSMIND1=0, FSMIND0ACK=1 → HS_ACK.
- HS_ACK: hold FSMIND0ACK until FSMIND0=0, then drop it. Advance frame, wrapping at num_pat. On wrap, increment pass.
  - If pass reaches exp_cnt: pulse done → IDLE.
  - Otherwise → PB_CMD.
- Counters are 16-bit. Address arithmetic is 30-bit and wraps silently.
- busy = state≠IDLE. frame_idx = current frame.

## Timing
- Reset (rst_n=0 at a clk edge) has priority over everything. All outputs become 0, state IDLE, counters 0, from the next edge. This also applies mid-burst; any partial MCB burst is abandoned.
- cmd_en is high exactly one cycle per burst, and only when cmd_full=0.
- Each write command is issued only after all BURST of its words have been pushed.
- Data moves are stall-tolerant: a word moves only in a cycle where its gating condition holds. No word is lost or duplicated.
- trig_load to first pi_rd_en: 2 cycles when calib_done is already high.
- FSMIND1 rises the cycle after the last mask word of a frame.
- FSMIND0ACK rises 1 cycle after FSMIND0 is sampled high (ack latched). It falls 1 cycle after FSMIND0 is sampled low.
- FSMIND0 arriving before FSMIND1ACK is held off until the ack arrives.

## Structure
- Shared package: state enum, MCB instruction constants (WR=3'b000, RD=3'b001), BURST and FRAME_WORDS defaults.
- One sub-module is natural: imager_fsmind_hs, holding the HS_REQ/HS_ACK handshake with a start input and a done output.

## Test plan
- Reset mid-LD_FILL (rst_n low 1 cycle) → all outputs 0, IDLE; a later trig_load restarts at address 0.
- num_pat=1, exp_cnt=1, 1440 words pi_data=k, no stalls → 45 write cmds at addr 0,128,…,5632; 45 reads; mask_data sequence 0..1439.
- num_pat=3, exp_cnt=2 → write bases 0, 5760, 11520; playback frame order 0,1,2,0,1,2; 6 handshakes; one done pulse.
- Sensor model: FSMIND1ACK 1000 cycles after FSMIND1, FSMIND0 2000 cycles after FSMIND1 → FSMIND1 falls on FSMIND0; FSMIND0ACK pulses; no new read until FSMIND0 drops.
- Random cmd_full, wr_full, mask_full and pi_empty stalls → data integrity is preserved and cmd_en never fires while cmd_full is high.
- num_pat=0, or exp_cnt=0 → done pulse, with zero read commands (and zero write commands for num_pat=0); calib_done held low → no commands issued, stays in WAIT_CAL.
